// File: rtl/srff_pkg.sv
// Shared constants and next-state rule for the SR flip-flop bank.
// Conflict-mode encodings plus the single-bit srff_next() function.
package srff_pkg;

    localparam int unsigned CM_HOLD = 0;
    localparam int unsigned CM_SET  = 1;
    localparam int unsigned CM_RST  = 2;
    localparam int unsigned CM_TOG  = 3;

    function automatic logic srff_next(
        input logic        q,
        input logic        s,
        input logic        r,
        input int unsigned mode
    );
        logic n;
        n = q;
        unique case (1'b1)
            (s & ~r): n = 1'b1;
            (~s & r): n = 1'b0;
            (s & r): begin
                // Out-of-range modes fall back to hold
                case (mode)
                    CM_SET:  n = 1'b1;
                    CM_RST:  n = 1'b0;
                    CM_TOG:  n = ~q;
                    default: n = q;
                endcase
            end
            default: n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/srff_cell.sv
// Single SR flip-flop: next-state decode plus the state register.
// q_next is the enabled next value, exported for edge detection.
module srff_cell
    import srff_pkg::*;
#(
    parameter int unsigned CONFLICT_MODE = CM_HOLD,
    parameter logic        RST_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic s,
    input  logic r,
    output logic q,
    output logic q_next
);

    assign q_next = srff_next(q, s, r, CONFLICT_MODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/srff_bank.sv
// Bank of WIDTH SR flip-flops with edge pulses, sticky conflict
// flags and a saturating count of conflicting enabled cycles.
module srff_bank
    import srff_pkg::*;
#(
    parameter int unsigned       WIDTH         = 8,
    parameter int unsigned       CONFLICT_MODE = CM_HOLD,
    parameter logic [WIDTH-1:0]  RST_VAL       = {WIDTH{1'b0}},
    parameter int unsigned       CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] conflict_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] cf;

    assign cf  = s & r;
    assign q_n = ~q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        srff_cell #(
            .CONFLICT_MODE(CONFLICT_MODE),
            .RST_VAL      (RST_VAL[i])
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .clr   (clr),
            .s     (s[i]),
            .r     (r[i]),
            .q     (q[i]),
            .q_next(q_nx[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise            <= '0;
            fall            <= '0;
            conflict_sticky <= '0;
            conflict_cnt    <= '0;
        end else if (clr) begin
            rise            <= '0;
            fall            <= '0;
            conflict_sticky <= '0;
            conflict_cnt    <= '0;
        end else if (en) begin
            rise            <= ~q & q_nx;
            fall            <= q & ~q_nx;
            conflict_sticky <= conflict_sticky | cf;
            // One count per cycle regardless of how many bits conflict
            if (|cf && conflict_cnt != CNT_MAX) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end else begin
            rise <= '0;
            fall <= '0;
        end
    end

    a_mode_legal : assert property (@(posedge clk) CONFLICT_MODE <= CM_TOG)
        else $error("srff_bank: illegal CONFLICT_MODE %0d", CONFLICT_MODE);

endmodule

// File: tb/tb_srff_bank.sv
// Self-checking bench: six srff_bank configurations share one stimulus
// stream and are compared against a per-configuration behavioural model.
module tb_srff_bank;

    localparam int N = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] s   = '0;
    logic [3:0] r   = '0;

    logic [3:0] q_o  [N];
    logic [3:0] qn_o [N];
    logic [3:0] ri_o [N];
    logic [3:0] fa_o [N];
    logic [3:0] st_o [N];
    logic [7:0] cnt_o[N];
    logic [2:0] cnt4;

    int npass = 0;
    int ntot  = 0;

    int mode_c[N] = '{0, 1, 2, 3, 0, 0};
    int rv_c  [N] = '{0, 0, 0, 0, 0, 5};
    int cmax_c[N] = '{255, 255, 255, 255, 7, 255};

    int mq[N], mr[N], mf[N], ms[N], mc[N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_mode
        srff_bank #(
            .WIDTH(4), .CONFLICT_MODE(k), .RST_VAL(4'b0000), .CNT_W(8)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r),
            .q(q_o[k]), .q_n(qn_o[k]), .rise(ri_o[k]), .fall(fa_o[k]),
            .conflict_sticky(st_o[k]), .conflict_cnt(cnt_o[k])
        );
    end

    srff_bank #(
        .WIDTH(4), .CONFLICT_MODE(0), .RST_VAL(4'b0000), .CNT_W(3)
    ) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r),
        .q(q_o[4]), .q_n(qn_o[4]), .rise(ri_o[4]), .fall(fa_o[4]),
        .conflict_sticky(st_o[4]), .conflict_cnt(cnt4)
    );
    assign cnt_o[4] = {5'b0, cnt4};

    srff_bank #(
        .WIDTH(4), .CONFLICT_MODE(0), .RST_VAL(4'b0101), .CNT_W(8)
    ) u_rv (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r),
        .q(q_o[5]), .q_n(qn_o[5]), .rise(ri_o[5]), .fall(fa_o[5]),
        .conflict_sticky(st_o[5]), .conflict_cnt(cnt_o[5])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k] = rv_c[k];
            mr[k] = 0; mf[k] = 0; ms[k] = 0; mc[k] = 0;
        end
    endtask

    // Rules applied bit by bit as integers: s/r win alone, mode decides both
    task automatic model_edge();
        for (int k = 0; k < N; k++) begin
            if (clr) begin
                mq[k] = rv_c[k];
                mr[k] = 0; mf[k] = 0; ms[k] = 0; mc[k] = 0;
            end else if (!en) begin
                mr[k] = 0; mf[k] = 0;
            end else begin
                int nq;
                nq = 0;
                for (int i = 0; i < 4; i++) begin
                    int ob, nb, sb, rb;
                    ob = (mq[k] >> i) & 1;
                    sb = s[i];
                    rb = r[i];
                    if (sb == 1 && rb == 0) nb = 1;
                    else if (sb == 0 && rb == 1) nb = 0;
                    else if (sb == 1 && rb == 1) begin
                        if (mode_c[k] == 1) nb = 1;
                        else if (mode_c[k] == 2) nb = 0;
                        else if (mode_c[k] == 3) nb = 1 - ob;
                        else nb = ob;
                    end else nb = ob;
                    nq += nb << i;
                end
                mr[k] = ~mq[k] & nq & 15;
                mf[k] = mq[k] & ~nq & 15;
                mq[k] = nq;
                ms[k] = ms[k] | (s & r);
                if ((s & r) != 0 && mc[k] < cmax_c[k]) mc[k] = mc[k] + 1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s.d%0d.q", ph, k), 32'(q_o[k]), mq[k]);
            chk($sformatf("%s.d%0d.q_n", ph, k), 32'(qn_o[k]), ~mq[k] & 15);
            chk($sformatf("%s.d%0d.rise", ph, k), 32'(ri_o[k]), mr[k]);
            chk($sformatf("%s.d%0d.fall", ph, k), 32'(fa_o[k]), mf[k]);
            chk($sformatf("%s.d%0d.sticky", ph, k), 32'(st_o[k]), ms[k]);
            chk($sformatf("%s.d%0d.cnt", ph, k), 32'(cnt_o[k]), mc[k]);
        end
    endtask

    task automatic cyc(input string ph, input logic e, input logic c,
                       input logic [3:0] sv, input logic [3:0] rv);
        @(negedge clk);
        en = e; clr = c; s = sv; r = rv;
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        cyc("set", 1, 0, 4'b0011, 4'b0000);
        cyc("rst", 1, 0, 4'b0000, 4'b0001);
        cyc("hold", 1, 0, 4'b0000, 4'b0000);

        cyc("clr0", 0, 1, 4'b0000, 4'b0000);
        cyc("conf1", 1, 0, 4'b1111, 4'b1111);
        cyc("conf2", 1, 0, 4'b1111, 4'b1111);

        for (int n = 0; n < 3; n++) cyc("gate", 0, 0, 4'b1111, 4'b1111);

        cyc("clr1", 1, 1, 4'b1111, 4'b0000);
        for (int n = 0; n < 9; n++) cyc("sat", 1, 0, 4'b0001, 4'b0001);

        cyc("clr2", 1, 1, 4'b0000, 4'b0000);
        for (int n = 0; n < 5; n++) cyc("pre", 1, 0, 4'b0001, 4'b0001);
        cyc("pre6", 1, 0, 4'b0110, 4'b0000);
        cyc("clrpri", 1, 1, 4'b1111, 4'b0000);

        cyc("arst0", 1, 0, 4'b1010, 4'b0101);
        @(negedge clk);
        en = 1'b0; s = '0; r = '0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk);
        check_all("arst_hold");
        rst = 1'b0;

        for (int n = 0; n < 300; n++) begin
            cyc("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                4'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
